tcp_tx_arbiter: RTL and testbench

Shares the SiTCP TCP transmit byte interface (TCP_TX_WR / TCP_TX_DATA / TCP_TX_FULL) among up to eight user byte-stream sources, such as button transport, LED echo and status reporters. Arbitration is round-robin and frame-based: a granted source keeps the link until its declared frame length is sent. Each frame is optionally prefixed with a 2-byte header so the host can demultiplex the streams. The block runs in the 200 MHz system clock domain, between the user modules and the SiTCP wrapper.

---
 rtl/tcp_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_tcp_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_tx_arbiter.sv
// tcp_tx_arbiter: round-robin, frame-based sharing of the SiTCP TCP TX byte port.
// Each granted source owns the link until its frame ends; optional 2-byte header.
module tcp_tx_arbiter #(
    parameter int N_CH   = 4,
    parameter bit HEADER = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tcp_open,
    input  logic              tx_full,
    output logic              tx_wr,
    output logic [7:0]        tx_data,
    input  logic [N_CH-1:0]   req,
    input  logic [8*N_CH-1:0] len,
    input  logic [N_CH-1:0]   src_valid,
    input  logic [8*N_CH-1:0] src_data,
    output logic [N_CH-1:0]   src_ready,
    output logic [N_CH-1:0]   grant,
    output logic              busy,
    output logic              abort,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        HDR0,
        HDR1,
        BODY
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        start_q, start_d;
    logic [2:0]        ch_q, ch_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        len_q, len_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic              wr_q, wr_d;
    logic [7:0]        data_q, data_d;
    logic              abort_q, abort_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic [2*N_CH-1:0] req_dbl;
    logic [2*N_CH-1:0] req_rot;
    logic              win_vld;
    logic [2:0]        win_ch;
    logic [7:0]        win_len;
    logic [N_CH-1:0]   win_oh;
    logic [3:0]        sum;
    logic [2:0]        nxt_ch;
    logic              sel_hs;
    logic [7:0]        sel_data;

    // Rotate requests so bit 0 is the search start; first set bit wins.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> start_q;

    always_comb begin
        win_vld = 1'b0;
        win_ch  = 3'd0;
        sum     = 4'd0;
        for (int i = 0; i < N_CH; i++) begin
            if (!win_vld && req_rot[i]) begin
                win_vld = 1'b1;
                sum     = {1'b0, start_q} + 4'(i);
                if (sum >= 4'(N_CH)) begin
                    sum = sum - 4'(N_CH);
                end
                win_ch = sum[2:0];
            end
        end
    end

    always_comb begin
        win_len  = 8'd0;
        win_oh   = '0;
        sel_data = 8'd0;
        for (int i = 0; i < N_CH; i++) begin
            if (win_ch == 3'(i)) begin
                win_len   = len[8*i +: 8];
                win_oh[i] = 1'b1;
            end
            if (ch_q == 3'(i)) begin
                sel_data = src_data[8*i +: 8];
            end
        end
    end

    assign nxt_ch = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;

    assign src_ready = (state_q == BODY) ?
                       (grant_q & {N_CH{~tx_full}}) : '0;
    assign sel_hs    = |(src_valid & src_ready);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        ch_d        = ch_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        grant_d     = grant_q;
        wr_d        = 1'b0;
        data_d      = data_q;
        abort_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;

        // Link loss wins over everything, including a final byte or tx_full.
        if (state_q != IDLE && !tcp_open) begin
            state_d = IDLE;
            grant_d = '0;
            abort_d = 1'b1;
            start_d = nxt_ch;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tcp_open && win_vld) begin
                        grant_d = win_oh;
                        ch_d    = win_ch;
                        cnt_d   = win_len;
                        len_d   = win_len;
                        state_d = HEADER ? HDR0 : BODY;
                    end
                end
                HDR0: begin
                    if (!tx_full) begin
                        wr_d    = 1'b1;
                        data_d  = {5'b10100, ch_q};
                        state_d = HDR1;
                    end
                end
                HDR1: begin
                    if (!tx_full) begin
                        wr_d    = 1'b1;
                        data_d  = len_q;
                        state_d = BODY;
                    end
                end
                BODY: begin
                    if (sel_hs) begin
                        wr_d   = 1'b1;
                        data_d = sel_data;
                        if (cnt_q == 8'd0) begin
                            frame_cnt_d = frame_cnt_q + 16'd1;
                            start_d     = nxt_ch;
                            grant_d     = '0;
                            state_d     = IDLE;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            start_q     <= 3'd0;
            ch_q        <= 3'd0;
            cnt_q       <= 8'd0;
            len_q       <= 8'd0;
            grant_q     <= '0;
            wr_q        <= 1'b0;
            data_q      <= 8'd0;
            abort_q     <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            ch_q        <= ch_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            grant_q     <= grant_d;
            wr_q        <= wr_d;
            data_q      <= data_d;
            abort_q     <= abort_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign tx_wr     = wr_q;
    assign tx_data   = data_q;
    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign abort     = abort_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tcp_tx_arbiter.sv
// Directed bench for tcp_tx_arbiter: scoreboard of expected TX bytes,
// one HEADER=1 instance for most scenarios and one HEADER=0 instance.
module tb_tcp_tx_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           tcp_open = 1'b0;
    logic           tx_full = 1'b0;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] len = '0;
    logic [N-1:0]   src_valid = '1;
    logic [8*N-1:0] src_data;
    logic           tx_wr;
    logic [7:0]     tx_data;
    logic [N-1:0]   src_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           abort;
    logic [15:0]    frame_cnt;

    logic           tx_full_z = 1'b0;
    logic [N-1:0]   req_z = '0;
    logic [8*N-1:0] len_z = '0;
    logic [N-1:0]   src_valid_z = '0;
    logic [8*N-1:0] src_data_z = '0;
    logic           tx_wr_z;
    logic [7:0]     tx_data_z;
    logic [N-1:0]   src_ready_z;
    logic [N-1:0]   grant_z;
    logic           busy_z;
    logic           abort_z;
    logic [15:0]    frame_cnt_z;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] q[$];
    logic [7:0] qz[$];
    logic [7:0] pay[N][256];
    int         acnt[N] = '{default: 0};
    int         base[N] = '{default: 0};

    always #5 clk = ~clk;

    tcp_tx_arbiter #(.N_CH(N), .HEADER(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .tcp_open(tcp_open), .tx_full(tx_full),
        .tx_wr(tx_wr), .tx_data(tx_data), .req(req), .len(len),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .grant(grant), .busy(busy), .abort(abort), .frame_cnt(frame_cnt)
    );

    tcp_tx_arbiter #(.N_CH(N), .HEADER(1'b0)) u_dut_z (
        .clk(clk), .rst_n(rst_n), .tcp_open(tcp_open), .tx_full(tx_full_z),
        .tx_wr(tx_wr_z), .tx_data(tx_data_z), .req(req_z), .len(len_z),
        .src_valid(src_valid_z), .src_data(src_data_z),
        .src_ready(src_ready_z), .grant(grant_z), .busy(busy_z),
        .abort(abort_z), .frame_cnt(frame_cnt_z)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Source model: each channel presents pay[c][k], k advancing per handshake.
    always_comb begin
        src_data = '0;
        for (int c = 0; c < N; c++) begin
            src_data[8*c +: 8] = pay[c][8'(acnt[c] - base[c])];
        end
    end

    always begin : src_drv
        logic [N-1:0] acc;
        @(negedge clk);
        #2;
        acc = src_valid & src_ready;
        @(posedge clk);
        #1;
        for (int c = 0; c < N; c++) begin
            if (acc[c]) acnt[c] = acnt[c] + 1;
        end
    end

    always @(negedge clk) begin
        if (tx_wr) begin
            if (q.size() == 0) check("unexpected_wr", 1, 0);
            else check("tx_data", {24'd0, tx_data}, {24'd0, q.pop_front()});
        end
        if (tx_wr_z) begin
            if (qz.size() == 0) check("unexpected_wr_z", 1, 0);
            else check("tx_data_z", {24'd0, tx_data_z}, {24'd0, qz.pop_front()});
        end
    end

    task automatic load(int c, int n, int b);
        for (int k = 0; k < 256; k++) pay[c][k] = 8'(b + k);
        base[c] = acnt[c];
        len[8*c +: 8] = 8'(n - 1);
    endtask

    task automatic push_frame(int c, int n);
        q.push_back(8'hA0 | 8'(c));
        q.push_back(8'(n - 1));
        for (int k = 0; k < n; k++) q.push_back(pay[c][k]);
    endtask

    task automatic wait_grant(string tag, logic [N-1:0] exp);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (grant != '0) break;
        end
        check(tag, {28'd0, grant}, {28'd0, exp});
    endtask

    task automatic wait_idle(string tag);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [N-1:0] order[4];
        logic [N-1:0] prev;
        int ng, run, wr, late, total, quiet, nw;
        logic acc;

        for (int c = 0; c < N; c++) load(c, 1, 0);
        repeat (2) @(negedge clk);
        check("rst_tx_wr", {31'd0, tx_wr}, 0);
        check("rst_tx_data", {24'd0, tx_data}, 0);
        check("rst_grant", {28'd0, grant}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_abort", {31'd0, abort}, 0);
        check("rst_frame_cnt", {16'd0, frame_cnt}, 0);
        check("rst_src_ready", {28'd0, src_ready}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        tcp_open = 1'b1;

        // Round-robin over req=1011, single-byte frames
        for (int c = 0; c < N; c++) load(c, 1, 16 * c + 1);
        q.push_back(8'hA0); q.push_back(8'h00); q.push_back(pay[0][0]);
        q.push_back(8'hA1); q.push_back(8'h00); q.push_back(pay[1][0]);
        q.push_back(8'hA3); q.push_back(8'h00); q.push_back(pay[3][0]);
        q.push_back(8'hA0); q.push_back(8'h00); q.push_back(pay[0][1]);
        req = 4'b1011;
        prev = '0;
        ng = 0;
        for (int k = 0; k < 4; k++) order[k] = '0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (grant != '0 && prev == '0) begin
                order[ng] = grant;
                ng++;
                if (ng == 4) begin
                    req = '0;
                    break;
                end
            end
            prev = grant;
        end
        check("rr_g0", {28'd0, order[0]}, 32'h1);
        check("rr_g1", {28'd0, order[1]}, 32'h2);
        check("rr_g2", {28'd0, order[2]}, 32'h8);
        check("rr_g3", {28'd0, order[3]}, 32'h1);
        wait_idle("rr_idle");
        repeat (2) @(negedge clk);
        check("rr_frame_cnt", {16'd0, frame_cnt}, 4);

        // Single source ch2, len=2, bytes 11 22 33
        load(2, 3, 0);
        pay[2][0] = 8'h11; pay[2][1] = 8'h22; pay[2][2] = 8'h33;
        push_frame(2, 3);
        req = 4'b0100;
        wait_grant("t1_grant", 4'b0100);
        req = '0;
        run = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (tx_wr) run++;
            else if (run > 0) break;
        end
        check("t1_run", run, 5);
        check("t1_grant_clr", {28'd0, grant}, 0);
        check("t1_frame_cnt", {16'd0, frame_cnt}, 5);
        check("t1_busy", {31'd0, busy}, 0);

        // Backpressure inside a 16-byte frame on ch1
        load(1, 16, 8'h40);
        push_frame(1, 16);
        req = 4'b0010;
        wait_grant("bp_grant", 4'b0010);
        req = '0;
        wr = 0;
        repeat (6) begin
            @(negedge clk);
            if (tx_wr) wr++;
        end
        tx_full = 1'b1;
        late = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_wr) late++;
        end
        check("bp_stop", late, 0);
        tx_full = 1'b0;
        @(negedge clk);
        check("bp_resume", {31'd0, tx_wr}, 1);
        total = wr + late + (tx_wr ? 1 : 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_wr) total++;
            if (!busy) break;
        end
        @(negedge clk);
        check("bp_total", total, 18);
        check("bp_frame_cnt", {16'd0, frame_cnt}, 6);

        // Abort on ch3 after 5 of 8 payload bytes
        load(3, 8, 8'h80);
        q.push_back(8'hA3);
        q.push_back(8'h07);
        for (int k = 0; k < 5; k++) q.push_back(pay[3][k]);
        req = 4'b1000;
        wait_grant("ab_grant", 4'b1000);
        req = '0;
        wr = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_wr) wr++;
            if (wr == 7) break;
        end
        tcp_open = 1'b0;
        @(negedge clk);
        check("ab_pulse", {31'd0, abort}, 1);
        check("ab_grant_clr", {28'd0, grant}, 0);
        check("ab_no_wr", {31'd0, tx_wr}, 0);
        @(negedge clk);
        check("ab_once", {31'd0, abort}, 0);
        load(0, 1, 8'hC0);
        req = 4'b1001;
        quiet = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_wr || grant != '0) quiet++;
        end
        check("ab_hold", quiet, 0);
        check("ab_frame_cnt", {16'd0, frame_cnt}, 6);
        push_frame(0, 1);
        tcp_open = 1'b1;
        wait_grant("ab_next", 4'b0001);
        req = '0;
        wait_idle("ab_idle");
        @(negedge clk);
        check("ab_after_cnt", {16'd0, frame_cnt}, 7);

        // Frame counter wrap
        @(negedge clk);
        force u_dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release u_dut.frame_cnt_q;
        load(2, 1, 8'h5A);
        push_frame(2, 1);
        req = 4'b0100;
        wait_grant("wrap_grant", 4'b0100);
        req = '0;
        wait_idle("wrap_idle");
        @(negedge clk);
        check("wrap_cnt", {16'd0, frame_cnt}, 0);

        // HEADER=0, 256-byte frame, src_valid toggling
        len_z[7:0] = 8'd255;
        req_z = 4'b0001;
        nw = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (tx_wr_z) begin
                nw++;
                if (nw == 255) check("z_busy_hi", {31'd0, busy_z}, 1);
                if (nw == 256) check("z_busy_drop", {31'd0, busy_z}, 0);
            end
            if (grant_z != '0) req_z = '0;
            src_valid_z[0] = ~src_valid_z[0];
            #1;
            acc = src_valid_z[0] & src_ready_z[0];
            if (acc) qz.push_back(src_data_z[7:0]);
            @(posedge clk);
            #1;
            if (acc) src_data_z[7:0] = src_data_z[7:0] + 8'd1;
        end
        check("z_writes", nw, 256);
        check("z_frame_cnt", {16'd0, frame_cnt_z}, 1);

        repeat (3) @(negedge clk);
        check("q_drained", q.size(), 0);
        check("qz_drained", qz.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
